// File: rtl/openstrive_soc_pkg.sv
// Shared SoC definitions for the memory bus adapter: FSM state encoding,
// memory word size and the byte-address to word-offset helper.
package openstrive_soc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    localparam int OPENSTRIVE_MEM_WORD_BYTES = 4;

    // Word offset from a byte address; wraps modulo 2^32, low address bits drop out.
    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> $clog2(OPENSTRIVE_MEM_WORD_BYTES);
    endfunction

endpackage

// File: rtl/openstrive_mem_bus_adapter_if.sv
// Request/grant/response data bus between a core (master) and the memory
// bus adapter (slave).
interface openstrive_mem_bus_adapter_if;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/openstrive_wait_counter.sv
// Down-counter for the adapter's wait states: load, decrement to zero, zero flag.
module openstrive_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/openstrive_mem_bus_adapter.sv
// Single-outstanding adapter from a req/gnt/rvalid data bus to a synchronous SRAM port.
// Define OPENSTRIVE_MEM_RANGE_CHECK_EN to reject word offsets >= WORDS with data_err_o.
module openstrive_mem_bus_adapter
    import openstrive_soc_pkg::*;
#(
    parameter int          WORDS       = 128,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    openstrive_mem_bus_adapter_if.slave   bus,
    output logic                          mem_ena_o,
    output logic [3:0]                    mem_wen_o,
    output logic [21:0]                   mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic [31:0]                   mem_rdata_i
);

    localparam int CNT_W     = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [21:0] offset_q, offset_d;
    logic        oor_q, oor_d;

    logic        gnt;
    logic        req_oor;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic        rvalid_c, err_c;
    logic [31:0] rdata_c;

`ifdef OPENSTRIVE_MEM_RANGE_CHECK_EN
    assign req_oor = (word_offset(bus.data_addr_i, BASE_ADDR) >= 32'(WORDS));
`else
    assign req_oor = 1'b0;
`endif

    assign gnt = bus.data_req_i && ((state_q == IDLE) || (state_q == RESP));

    openstrive_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (CNT_W'(WAIT_LOAD)),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0;
            offset_q <= 22'h0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            offset_q <= offset_d;
            oor_q    <= oor_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        offset_d    = offset_q;
        oor_d       = oor_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        mem_ena_o   = 1'b0;
        mem_wen_o   = 4'b0000;
        mem_addr_o  = 22'h0;
        mem_wdata_o = 32'h0;
        rvalid_c    = 1'b0;
        rdata_c     = 32'h0;
        err_c       = 1'b0;

        case (state_q)
            IDLE: ;
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = ACCESS;
            end
            ACCESS: begin
                // A flagged out-of-range access still walks ACCESS so latency is unchanged.
                mem_ena_o   = !oor_q;
                mem_wen_o   = (we_q && !oor_q) ? be_q : 4'b0000;
                mem_addr_o  = offset_q;
                mem_wdata_o = wdata_q;
                state_d     = RESP;
            end
            RESP: begin
                rvalid_c = 1'b1;
                rdata_c  = (we_q || oor_q) ? 32'h0 : mem_rdata_i;
`ifdef OPENSTRIVE_MEM_RANGE_CHECK_EN
                err_c    = oor_q;
`endif
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (gnt) begin
            we_d     = bus.data_we_i;
            be_d     = bus.data_be_i;
            wdata_d  = bus.data_wdata_i;
            offset_d = 22'(word_offset(bus.data_addr_i, BASE_ADDR));
            oor_d    = req_oor;
            if (WAIT_STATES > 0) begin
                state_d  = WAIT;
                cnt_load = 1'b1;
            end else begin
                state_d  = ACCESS;
            end
        end

        // Reset silences the memory and response sides in the reset cycle itself.
        if (rst) begin
            mem_ena_o   = 1'b0;
            mem_wen_o   = 4'b0000;
            mem_addr_o  = 22'h0;
            mem_wdata_o = 32'h0;
            rvalid_c    = 1'b0;
            rdata_c     = 32'h0;
            err_c       = 1'b0;
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_c;
    assign bus.data_rdata_o  = rdata_c;
    assign bus.data_err_o    = err_c;

endmodule

// File: tb/tb_openstrive_mem_bus_adapter.sv
// Directed bench: a zero-wait adapter at base 0 and a three-wait adapter at base
// 0x1000_0000, each driving a small synchronous memory model.
module tb_openstrive_mem_bus_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_d, we_d;
    logic [3:0]  be_d;
    logic [31:0] addr_d, wdata_d;

    openstrive_mem_bus_adapter_if bus0();
    openstrive_mem_bus_adapter_if bus3();

    assign bus0.data_req_i   = req_d && !sel;
    assign bus0.data_we_i    = we_d;
    assign bus0.data_be_i    = be_d;
    assign bus0.data_addr_i  = addr_d;
    assign bus0.data_wdata_i = wdata_d;
    assign bus3.data_req_i   = req_d && sel;
    assign bus3.data_we_i    = we_d;
    assign bus3.data_be_i    = be_d;
    assign bus3.data_addr_i  = addr_d;
    assign bus3.data_wdata_i = wdata_d;

    logic        m0_ena, m3_ena;
    logic [3:0]  m0_wen, m3_wen;
    logic [21:0] m0_addr, m3_addr;
    logic [31:0] m0_wdata, m3_wdata, m0_rdata, m3_rdata;

    openstrive_mem_bus_adapter #(
        .WORDS(128), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .mem_ena_o(m0_ena), .mem_wen_o(m0_wen), .mem_addr_o(m0_addr),
        .mem_wdata_o(m0_wdata), .mem_rdata_i(m0_rdata)
    );

    openstrive_mem_bus_adapter #(
        .WORDS(128), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .mem_ena_o(m3_ena), .mem_wen_o(m3_wen), .mem_addr_o(m3_addr),
        .mem_wdata_o(m3_wdata), .mem_rdata_i(m3_rdata)
    );

    logic [31:0] mem0 [0:255];
    logic [31:0] mem3 [0:255];

    always @(posedge clk) begin
        if (m0_ena) begin
            for (int b = 0; b < 4; b++)
                if (m0_wen[b]) mem0[m0_addr[7:0]][8*b +: 8] <= m0_wdata[8*b +: 8];
            m0_rdata <= mem0[m0_addr[7:0]];
        end
        if (m3_ena) begin
            for (int b = 0; b < 4; b++)
                if (m3_wen[b]) mem3[m3_addr[7:0]][8*b +: 8] <= m3_wdata[8*b +: 8];
            m3_rdata <= mem3[m3_addr[7:0]];
        end
    end

    logic        obs_gnt, obs_rvalid, obs_err, obs_ena;
    logic [31:0] obs_rdata;
    logic [21:0] obs_maddr;
    logic [3:0]  obs_wen;
    assign obs_gnt    = sel ? bus3.data_gnt_o    : bus0.data_gnt_o;
    assign obs_rvalid = sel ? bus3.data_rvalid_o : bus0.data_rvalid_o;
    assign obs_err    = sel ? bus3.data_err_o    : bus0.data_err_o;
    assign obs_rdata  = sel ? bus3.data_rdata_o  : bus0.data_rdata_o;
    assign obs_ena    = sel ? m3_ena  : m0_ena;
    assign obs_maddr  = sel ? m3_addr : m0_addr;
    assign obs_wen    = sel ? m3_wen  : m0_wen;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // One request, then 12 cycles of observation counted from the grant cycle.
    task automatic xfer(input logic w, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output int lat,
                        output int ena_cyc, output logic [21:0] ena_addr,
                        output logic [3:0] ena_wen, output logic err, output int nvalid);
        logic granted;
        rdata = 32'h0; lat = -1; ena_cyc = -1; ena_addr = 22'h0; ena_wen = 4'h0;
        err = 1'b0; nvalid = 0; granted = 1'b0;
        @(negedge clk);
        req_d = 1'b1; we_d = w; be_d = be; addr_d = addr; wdata_d = wd;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (obs_gnt) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("gnt_seen", {31'b0, granted}, 32'd1);
        @(negedge clk);
        req_d = 1'b0;
        #1;
        if (!granted) return;
        for (int c = 1; c <= 12; c++) begin
            if (obs_ena && ena_cyc < 0) begin
                ena_cyc = c; ena_addr = obs_maddr; ena_wen = obs_wen;
            end
            if (obs_rvalid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c; rdata = obs_rdata; err = obs_err;
                end
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, ec, nv, idx, nrv;
        logic [21:0] ea;
        logic [3:0]  ew;
        logic        er;
        logic [11:0] gv, ev, vv;
        logic [12:0] gv3, ev3, vv3;
        logic [31:0] rds [4];
        logic [31:0] wvals [4];

        wvals[0] = 32'hA0A0_0001; wvals[1] = 32'hB1B1_0002;
        wvals[2] = 32'hC2C2_0003; wvals[3] = 32'hD3D3_0004;

        sel = 1'b0; req_d = 1'b0; we_d = 1'b0; be_d = 4'h0; addr_d = 32'h0; wdata_d = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rvalid0", {31'b0, bus0.data_rvalid_o}, 32'd0);
        check("rst_rdata0",  bus0.data_rdata_o, 32'h0);
        check("rst_err0",    {31'b0, bus0.data_err_o}, 32'd0);
        check("rst_ena0",    {31'b0, m0_ena}, 32'd0);
        check("rst_ena3",    {31'b0, m3_ena}, 32'd0);
        check("rst_rvalid3", {31'b0, bus3.data_rvalid_o}, 32'd0);
        check("rst_gnt_noreq", {31'b0, bus0.data_gnt_o}, 32'd0);
        req_d = 1'b1;
        #1;
        check("rst_gnt_follows_req", {31'b0, bus0.data_gnt_o}, 32'd1);
        req_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Full-word write then readback, zero wait states
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat, ec, ea, ew, er, nv);
        check("wr_mem_addr", {10'b0, ea}, 32'd4);
        check("wr_wen", {28'b0, ew}, 32'hF);
        check("wr_lat", lat, 32'd2);
        check("wr_rdata_zero", rd, 32'h0);
        check("wr_err", {31'b0, er}, 32'd0);
        xfer(1'b0, 4'hF, 32'h10, 32'h0, rd, lat, ec, ea, ew, er, nv);
        check("rd_ena_cyc", ec, 32'd1);
        check("rd_mem_addr", {10'b0, ea}, 32'd4);
        check("rd_wen_zero", {28'b0, ew}, 32'h0);
        check("rd_lat", lat, 32'd2);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_nvalid", nv, 32'd1);

        // Byte-lane write, then readback through a misaligned address
        xfer(1'b1, 4'b0010, 32'h10, 32'h0000AB00, rd, lat, ec, ea, ew, er, nv);
        check("bw_wen", {28'b0, ew}, 32'h2);
        xfer(1'b0, 4'hF, 32'h13, 32'h0, rd, lat, ec, ea, ew, er, nv);
        check("bw_mem_addr", {10'b0, ea}, 32'd4);
        check("bw_readback", rd, 32'hDEADABEF);

        // Back-to-back reads with req held high
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 4'hF, 32'h20 + 32'(i * 4), wvals[i], rd, lat, ec, ea, ew, er, nv);
        idx = 0; nrv = 0; gv = '0; ev = '0; vv = '0;
        @(negedge clk);
        req_d = 1'b1; we_d = 1'b0; be_d = 4'hF; addr_d = 32'h20;
        #1;
        for (int c = 0; c < 12; c++) begin
            gv[c] = obs_gnt; ev[c] = obs_ena; vv[c] = obs_rvalid;
            if (obs_rvalid) begin
                if (nrv < 4) rds[nrv] = obs_rdata;
                nrv++;
            end
            if (obs_gnt) idx++;
            @(negedge clk);
            req_d = (idx < 4);
            addr_d = 32'h20 + 32'(idx * 4);
            #1;
        end
        req_d = 1'b0;
        check("b2b_gnt_cycles", {20'b0, gv}, 32'h055);
        check("b2b_ena_cycles", {20'b0, ev}, 32'h0AA);
        check("b2b_rvalid_cycles", {20'b0, vv}, 32'h154);
        check("b2b_rvalid_count", nrv, 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_rdata%0d", i), rds[i], wvals[i]);

        // Offset beyond WORDS
        xfer(1'b0, 4'hF, 32'h200, 32'h0, rd, lat, ec, ea, ew, er, nv);
        check("oor_lat", lat, 32'd2);
`ifdef OPENSTRIVE_MEM_RANGE_CHECK_EN
        check("oor_no_ena", ec, 32'hFFFF_FFFF);
        check("oor_err", {31'b0, er}, 32'd1);
        check("oor_rdata", rd, 32'h0);
`else
        check("oor_mem_addr", {10'b0, ea}, 32'd128);
        check("oor_err", {31'b0, er}, 32'd0);
`endif

        // Three wait states, base 0x1000_0000
        sel = 1'b1;
        xfer(1'b1, 4'hF, 32'h1000_0010, 32'h12345678, rd, lat, ec, ea, ew, er, nv);
        check("w3_wr_mem_addr", {10'b0, ea}, 32'd4);
        check("w3_wr_lat", lat, 32'd5);
        xfer(1'b1, 4'hF, 32'h1000_0014, 32'hCAFEF00D, rd, lat, ec, ea, ew, er, nv);
        check("w3_wr2_mem_addr", {10'b0, ea}, 32'd5);

        nrv = 0; gv3 = '0; ev3 = '0; vv3 = '0;
        @(negedge clk);
        req_d = 1'b1; we_d = 1'b0; be_d = 4'hF; addr_d = 32'h1000_0010;
        #1;
        for (int c = 0; c < 13; c++) begin
            gv3[c] = obs_gnt; ev3[c] = obs_ena; vv3[c] = obs_rvalid;
            if (obs_rvalid) begin
                if (nrv < 4) rds[nrv] = obs_rdata;
                nrv++;
            end
            @(negedge clk);
            req_d = (c + 1 <= 5);
            addr_d = 32'h1000_0014;
            #1;
        end
        req_d = 1'b0;
        check("w3_gnt_cycles", {19'b0, gv3}, 32'h021);
        check("w3_ena_cycles", {19'b0, ev3}, 32'h210);
        check("w3_rvalid_cycles", {19'b0, vv3}, 32'h420);
        check("w3_rdata0", rds[0], 32'h12345678);
        check("w3_rdata1", rds[1], 32'hCAFEF00D);

        // Address below base wraps modulo 2^32
        xfer(1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0, rd, lat, ec, ea, ew, er, nv);
`ifdef OPENSTRIVE_MEM_RANGE_CHECK_EN
        check("wrap_err", {31'b0, er}, 32'd1);
`else
        check("wrap_mem_addr", {10'b0, ea}, 32'h3FFFFF);
        check("wrap_err", {31'b0, er}, 32'd0);
`endif

        // Reset pulse in the last wait cycle before ACCESS
        @(negedge clk);
        req_d = 1'b1; we_d = 1'b0; be_d = 4'hF; addr_d = 32'h1000_0010;
        #1;
        check("rs_gnt", {31'b0, obs_gnt}, 32'd1);
        @(negedge clk);
        req_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_no_ena_in_rst", {31'b0, obs_ena}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        ec = 0; nv = 0;
        for (int c = 0; c < 8; c++) begin
            if (obs_ena) ec++;
            if (obs_rvalid) nv++;
            @(negedge clk); #1;
        end
        check("rs_ena_count", ec, 32'd0);
        check("rs_rvalid_count", nv, 32'd0);
        xfer(1'b0, 4'hF, 32'h1000_0010, 32'h0, rd, lat, ec, ea, ew, er, nv);
        check("rs_after_lat", lat, 32'd5);
        check("rs_after_ena_cyc", ec, 32'd4);
        check("rs_after_data", rd, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/openstrive_mem_bus_adapter.md
OPENSTRIVE_MEM_BUS_ADAPTER -- requirements
Module: openstrive_mem_bus_adapter

Interface
REQ-001 SHALL have parameter WORDS, default 128, memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to memory word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted between accept and memory strobe.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports data_req_i in 1 request; data_gnt_o out 1 grant; data_we_i in 1 write; data_be_i in 4 byte enables.
REQ-007 SHALL have ports data_addr_i in 32 byte address; data_wdata_i in 32 write data.
REQ-008 SHALL have ports data_rvalid_o out 1 response valid; data_rdata_o out 32 read data; data_err_o out 1 error.
REQ-009 SHALL have ports mem_ena_o out 1; mem_wen_o out 4; mem_addr_o out 22 word address; mem_wdata_o out 32; mem_rdata_i in 32 (memory returns data one cycle after ena).

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-011 data_gnt_o SHALL equal data_req_i while state is IDLE or RESP, else 0 (combinational).
REQ-012 On grant SHALL latch we, be, wdata, word offset ((data_addr_i - BASE_ADDR) >> 2) and go to WAIT if WAIT_STATES>0, else ACCESS.
REQ-013 WAIT SHALL load counter with WAIT_STATES-1 on entry, decrement each cycle, go to ACCESS when counter is 0.
REQ-014 In ACCESS SHALL drive mem_ena_o=1, mem_addr_o=latched offset[21:0], mem_wen_o=latched be if we else 4'b0000, mem_wdata_o=latched wdata; next state RESP.
REQ-015 mem_ena_o and mem_wen_o SHALL be 0 in every state other than ACCESS.
REQ-016 In RESP SHALL assert data_rvalid_o for exactly one cycle; data_rdata_o=mem_rdata_i for reads, 32'h0 for writes.
REQ-017 From RESP SHALL go to ACCESS/WAIT if a new request is granted that cycle, else IDLE; at most one outstanding transaction.
REQ-018 Read latency, grant to rvalid, SHALL be 2+WAIT_STATES cycles; peak throughput one access per 2+WAIT_STATES cycles.
REQ-019 data_addr_i[1:0] SHALL be ignored; offset arithmetic SHALL be 32-bit modulo 2^32.
REQ-020 data_rdata_o SHALL be 0 whenever data_rvalid_o is 0.

Reset
REQ-021 rst SHALL force state IDLE, counter 0, latched registers 0, all outputs 0 except data_gnt_o which follows REQ-011.
REQ-022 rst asserted mid-transaction SHALL abandon it: no memory strobe after the reset cycle, no rvalid issued for it.

Configuration
REQ-023 With macro OPENSTRIVE_MEM_RANGE_CHECK_EN defined, an access whose word offset >= WORDS SHALL be flagged at grant, SHALL NOT assert mem_ena_o in ACCESS, and SHALL return data_rvalid_o=1, data_err_o=1, data_rdata_o=0 in RESP.
REQ-024 Without the macro, data_err_o SHALL be tied 0 and offsets SHALL wrap into mem_addr_o[21:0] unchecked.

Structure
REQ-025 FSM state enum and an OPENSTRIVE_MEM_WORD_BYTES=4 constant SHALL live in shared package openstrive_soc_pkg.
REQ-026 Wait counter SHALL be sub-module openstrive_wait_counter (load, decrement, zero flag); no other sub-modules.

Verification
REQ-027 WAIT_STATES=0: write addr 0x10, be 4'hF, data 0xDEADBEEF, then read 0x10 -> mem strobe at addr 4, rvalid 2 cycles after grant, rdata 0xDEADBEEF.
REQ-028 Byte write be 4'b0010 data 0x0000AB00 over 0xDEADBEEF -> mem_wen_o 4'b0010; readback 0xDEADABEF.
REQ-029 WAIT_STATES=3: read -> mem_ena_o exactly 4 cycles after grant, rvalid 5 cycles after grant, data_gnt_o 0 during WAIT/ACCESS.
REQ-030 req held high for 4 back-to-back reads -> grants in RESP cycles, one access per 2 cycles, no dropped or duplicated rvalid.
REQ-031 Macro defined, WORDS=128, read addr 0x200 -> no mem_ena_o, rvalid with err=1, rdata 0; without macro -> mem_addr_o 128, err 0.
REQ-032 rst pulse in ACCESS-pending cycle -> state IDLE, no rvalid, next request serviced normally.
